// File: rtl/hwpe_multistream_ctrl_fsm.sv
// Multi-stream HWPE control FSM sequencing streamer, engine and uloop.
// Optional watchdog abort: define HWPE_MULTISTREAM_FSM_WATCHDOG_EN.
module hwpe_multistream_ctrl_fsm #(
    parameter int NUM_SRC  = 3,
    parameter int NUM_SNK  = 1,
    parameter int LEN_W    = 16,
    parameter int ADDR_W   = 32,
    parameter int NUM_OFFS = 4,
    parameter int WDOG_W   = 20,
    localparam int NS      = NUM_SRC + NUM_SNK,
    localparam int OW      = (NUM_OFFS > 1) ? $clog2(NUM_OFFS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    input  logic [NS-1:0]          stream_en_i,
    input  logic [NS*ADDR_W-1:0]   base_addr_i,
    input  logic [NS*OW-1:0]       offs_sel_i,
    input  logic [NUM_OFFS*ADDR_W-1:0] uloop_offs_i,
    input  logic                   uloop_valid_i,
    input  logic                   uloop_done_i,
    output logic                   uloop_enable_o,
    output logic                   uloop_clear_o,
    input  logic [NS-1:0]          ready_start_i,
    output logic [NS-1:0]          req_start_o,
    output logic [NS*ADDR_W-1:0]   stream_addr_o,
    output logic [LEN_W-1:0]       trans_size_o,
    input  logic [LEN_W-1:0]       eng_cnt_i,
    input  logic                   eng_acc_valid_i,
    output logic                   eng_start_o,
    output logic                   eng_clear_o,
    output logic                   eng_enable_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   evt_o,
    output logic [15:0]            tile_cnt_o,
    output logic                   abort_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_COMPUTE,
        S_UPDATEIDX,
        S_TERMINATE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_tile_cnt;
    logic        w_rdy;
    logic        w_go;
    logic        w_tile_clr;
    logic        w_tile_inc;
    logic [OW-1:0] w_sel;

    // Disabled streams count as ready so they never block a job.
    assign w_rdy        = &(ready_start_i | ~stream_en_i);
    assign req_start_o  = w_go ? stream_en_i : '0;
    assign eng_start_o  = w_go;
    assign evt_o        = done_o;
    assign busy_o       = (r_state != S_IDLE);
    assign tile_cnt_o   = r_tile_cnt;
    assign trans_size_o = len_i;

    always_comb begin
        stream_addr_o = '0;
        w_sel         = '0;
        for (int i = 0; i < NS; i++) begin
            w_sel = offs_sel_i[i*OW +: OW];
            stream_addr_o[i*ADDR_W +: ADDR_W] =
                base_addr_i[i*ADDR_W +: ADDR_W] +
                uloop_offs_i[int'(w_sel)*ADDR_W +: ADDR_W];
        end
    end

`ifdef HWPE_MULTISTREAM_FSM_WATCHDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              w_wdog_act;
    logic              w_wdog_hit;
    logic              w_abort;

    assign w_wdog_act = (r_state == S_WAIT) || (r_state == S_COMPUTE) ||
                        (r_state == S_TERMINATE);
    assign w_wdog_hit = w_wdog_act && (&r_wdog);
    assign abort_o    = w_abort;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog <= '0;
        end else if (clear_i || !w_wdog_act || (w_next != r_state)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    logic w_unused_wdog;
    assign w_unused_wdog = (WDOG_W > 0);
    assign abort_o       = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        w_go           = 1'b0;
        w_tile_clr     = 1'b0;
        w_tile_inc     = 1'b0;
        uloop_enable_o = 1'b0;
        uloop_clear_o  = 1'b0;
        eng_clear_o    = 1'b0;
        eng_enable_o   = 1'b1;
        done_o         = 1'b0;
`ifdef HWPE_MULTISTREAM_FSM_WATCHDOG_EN
        w_abort        = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                uloop_clear_o = 1'b1;
                eng_clear_o   = 1'b1;
                if (start_i) begin
                    w_next     = S_START;
                    w_tile_clr = 1'b1;
                end
            end
            S_START: begin
                if (w_rdy) begin
                    w_go   = 1'b1;
                    w_next = S_COMPUTE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rdy) begin
                    w_go   = 1'b1;
                    w_next = S_COMPUTE;
                end else begin
                    eng_enable_o = 1'b0;
                end
            end
            S_COMPUTE: begin
                if ((eng_cnt_i == len_i) && eng_acc_valid_i) begin
                    w_next     = S_UPDATEIDX;
                    w_tile_inc = 1'b1;
                end
            end
            S_UPDATEIDX: begin
                if (!uloop_valid_i) begin
                    uloop_enable_o = 1'b1;
                end else if (uloop_done_i) begin
                    w_next = S_TERMINATE;
                end else if (w_rdy) begin
                    w_go   = 1'b1;
                    w_next = S_COMPUTE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_TERMINATE: begin
                eng_enable_o = 1'b0;
                if (w_rdy) begin
                    done_o = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
`ifdef HWPE_MULTISTREAM_FSM_WATCHDOG_EN
        // Abort keeps the tile count so software can see how far the job got.
        if (w_wdog_hit) begin
            w_next     = S_IDLE;
            w_go       = 1'b0;
            w_tile_inc = 1'b0;
            done_o     = 1'b1;
            w_abort    = 1'b1;
        end
`endif
        if (clear_i) begin
            w_next         = S_IDLE;
            w_go           = 1'b0;
            w_tile_clr     = 1'b1;
            w_tile_inc     = 1'b0;
            uloop_enable_o = 1'b0;
            uloop_clear_o  = 1'b1;
            eng_clear_o    = 1'b1;
            eng_enable_o   = 1'b1;
            done_o         = 1'b0;
`ifdef HWPE_MULTISTREAM_FSM_WATCHDOG_EN
            w_abort        = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tile_cnt <= '0;
        end else if (w_tile_clr) begin
            r_tile_cnt <= '0;
        end else if (w_tile_inc && (r_tile_cnt != 16'hFFFF)) begin
            r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hwpe_multistream_ctrl_fsm.sv
// Directed self-checking bench for hwpe_multistream_ctrl_fsm (default build).
module tb_hwpe_multistream_ctrl_fsm;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         start;
    logic [15:0]  len;
    logic [3:0]   en;
    logic [127:0] base;
    logic [7:0]   sel;
    logic [127:0] offs;
    logic         ul_valid;
    logic         ul_done;
    logic         ul_enable;
    logic         ul_clear;
    logic [3:0]   ready;
    logic [3:0]   req;
    logic [127:0] saddr;
    logic [15:0]  tsize;
    logic [15:0]  ecnt;
    logic         evalid;
    logic         estart;
    logic         eclear;
    logic         eenable;
    logic         busy;
    logic         done;
    logic         evt;
    logic [15:0]  tiles;
    logic         abort;

    int n_chk;
    int n_fail;

    hwpe_multistream_ctrl_fsm dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .len_i          (len),
        .stream_en_i    (en),
        .base_addr_i    (base),
        .offs_sel_i     (sel),
        .uloop_offs_i   (offs),
        .uloop_valid_i  (ul_valid),
        .uloop_done_i   (ul_done),
        .uloop_enable_o (ul_enable),
        .uloop_clear_o  (ul_clear),
        .ready_start_i  (ready),
        .req_start_o    (req),
        .stream_addr_o  (saddr),
        .trans_size_o   (tsize),
        .eng_cnt_i      (ecnt),
        .eng_acc_valid_i(evalid),
        .eng_start_o    (estart),
        .eng_clear_o    (eclear),
        .eng_enable_o   (eenable),
        .busy_o         (busy),
        .done_o         (done),
        .evt_o          (evt),
        .tile_cnt_o     (tiles),
        .abort_o        (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        len      = 16'd8;
        en       = 4'hF;
        ready    = 4'hF;
        base     = '0;
        sel      = '0;
        offs     = '0;
        ul_valid = 1'b0;
        ul_done  = 1'b0;
        ecnt     = '0;
        evalid   = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_ulclr", ul_clear, 1);
        chk("rst_eclr", eclear, 1);
        chk("rst_een", eenable, 1);
        chk("rst_req", req, 0);
        chk("rst_done", done, 0);
        chk("rst_tiles", tiles, 0);
        chk("rst_abort", abort, 0);
        rst_n = 1'b1;
        tick();

        // Two-tile job, all streams enabled and ready
        start = 1'b1;
        #1;
        chk("t1_idle_req", req, 0);
        tick();
        start = 1'b0;
        #1;
        chk("t1_start_busy", busy, 1);
        chk("t1_start_req", req, 4'hF);
        chk("t1_start_estart", estart, 1);
        chk("t1_start_eclr", eclear, 0);
        tick();
        chk("t1_comp_req", req, 0);
        chk("t1_comp_een", eenable, 1);
        ecnt   = 16'd8;
        evalid = 1'b1;
        tick();
        evalid   = 1'b0;
        ul_valid = 1'b0;
        #1;
        chk("t1_upd_tiles", tiles, 1);
        chk("t1_upd_ulen", ul_enable, 1);
        chk("t1_upd_noreq", req, 0);
        tick();
        ul_valid = 1'b1;
        #1;
        chk("t1_upd_go", req, 4'hF);
        tick();
        evalid = 1'b1;
        tick();
        evalid  = 1'b0;
        ul_done = 1'b1;
        #1;
        chk("t1_upd2_tiles", tiles, 2);
        chk("t1_upd2_req", req, 0);
        tick();
        chk("t1_term_done", done, 1);
        chk("t1_term_evt", evt, 1);
        chk("t1_term_een", eenable, 0);
        chk("t1_term_busy", busy, 1);
        tick();
        ul_done = 1'b0;
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_done", done, 0);
        chk("t1_idle_tiles", tiles, 2);

        // Stream 2 not ready: WAIT then go
        ready = 4'b1011;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("t2_start_req", req, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_wait_een", eenable, 0);
            chk("t2_wait_req", req, 0);
        end
        ready = 4'hF;
        #1;
        chk("t2_go_req", req, 4'hF);
        chk("t2_go_estart", estart, 1);
        chk("t2_go_een", eenable, 1);
        tick();
        evalid = 1'b1;
        tick();
        evalid  = 1'b0;
        ul_done = 1'b1;
        tick();
        ready = 4'b1011;
        #1;
        chk("t2_term_hold", done, 0);
        tick();
        chk("t2_term_hold2", busy, 1);
        ready = 4'hF;
        #1;
        chk("t2_term_done", done, 1);
        tick();
        ul_done = 1'b0;
        #1;
        chk("t2_idle", busy, 0);

        // Stream 2 disabled and stuck, len = 0
        en    = 4'b1011;
        ready = 4'b1011;
        len   = 16'd0;
        ecnt  = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("t3_start_req", req, 4'b1011);
        tick();
        evalid = 1'b1;
        tick();
        evalid   = 1'b0;
        ul_valid = 1'b1;
        ul_done  = 1'b1;
        #1;
        chk("t3_tiles", tiles, 1);
        tick();
        chk("t3_done", done, 1);
        tick();
        ul_done = 1'b0;
        #1;
        chk("t3_idle", busy, 0);
        chk("t3_tsize", tsize, 0);

        // Address generation and wrap
        base[32 +: 32] = 32'h0000_1000;
        sel[2 +: 2]    = 2'd1;
        offs[32 +: 32] = 32'h0000_0040;
        base[96 +: 32] = 32'hFFFF_FFF0;
        sel[6 +: 2]    = 2'd2;
        offs[64 +: 32] = 32'h0000_0020;
        #1;
        chk("addr_s1", saddr[32 +: 32], 32'h0000_1040);
        chk("addr_s3_wrap", saddr[96 +: 32], 32'h0000_0010);
        chk("addr_s0", saddr[0 +: 32], 32'h0);

        // Clear mid-COMPUTE with a coincident tile completion
        en    = 4'hF;
        ready = 4'hF;
        len   = 16'd8;
        ecnt  = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        evalid = 1'b1;
        tick();
        evalid = 1'b0;
        #1;
        chk("t5_tiles1", tiles, 1);
        chk("t5_go", req, 4'hF);
        tick();
        evalid = 1'b1;
        clear  = 1'b1;
        #1;
        chk("t5_clr_done", done, 0);
        chk("t5_clr_ulclr", ul_clear, 1);
        tick();
        clear  = 1'b0;
        evalid = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_tiles0", tiles, 0);
        chk("t5_done", done, 0);

        // No streams enabled: engine-only go
        en    = 4'h0;
        ready = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("t6_req", req, 0);
        chk("t6_estart", estart, 1);
        chk("t6_abort", abort, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_multistream_ctrl_fsm.md
Name: hwpe_multistream_ctrl_fsm

Overview:
- Parametrised control FSM for HWPE accelerators with NUM_SRC source streams, NUM_SNK sink streams and one engine, sequenced by the uloop index generator.
- Sits between the slave register file, the streamer, the engine and the uloop, in the position of the current single-purpose MAC controller.
- New behaviour: per-stream enable mask, per-stream offset selection, tile counter, busy flag, done/event pulses, optional watchdog abort.

Parameters:
- NUM_SRC, 3, number of source streams (1..8)
- NUM_SNK, 1, number of sink streams (1..4)
- LEN_W, 16, width of len_i and eng_cnt_i
- ADDR_W, 32, width of base and offset addresses
- NUM_OFFS, 4, number of uloop offset registers
- WDOG_W, 20, watchdog counter width (used only with the macro)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear, forces IDLE
- start_i  in  1  job start pulse from the slave
- len_i  in  LEN_W  elements per tile
- stream_en_i  in  NUM_SRC+NUM_SNK  stream enable mask; sources in the LSBs
- base_addr_i  in  (NUM_SRC+NUM_SNK)*ADDR_W  per-stream base address
- offs_sel_i  in  (NUM_SRC+NUM_SNK)*$clog2(NUM_OFFS)  uloop offset index per stream
- uloop_offs_i  in  NUM_OFFS*ADDR_W  uloop offsets
- uloop_valid_i  in  1  uloop indices valid
- uloop_done_i  in  1  uloop finished
- uloop_enable_o  out  1  advance the uloop
- uloop_clear_o  out  1  clear the uloop
- ready_start_i  in  NUM_SRC+NUM_SNK  streamer ready_start flags
- req_start_o  out  NUM_SRC+NUM_SNK  streamer start pulses
- stream_addr_o  out  (NUM_SRC+NUM_SNK)*ADDR_W  per-stream base address (base plus selected offset)
- trans_size_o  out  LEN_W  equal to len_i
- eng_cnt_i  in  LEN_W  engine element counter
- eng_acc_valid_i  in  1  engine accumulator valid
- eng_start_o  out  1  engine start pulse
- eng_clear_o  out  1  engine clear
- eng_enable_o  out  1  engine enable
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-done pulse
- evt_o  out  1  one-cycle event pulse, coincident with done_o
- tile_cnt_o  out  16  number of tiles completed in the current job
- abort_o  out  1  watchdog abort pulse (tied 0 without the macro)

Behaviour:
- rdy: AND over all streams of (ready_start_i[i] OR NOT stream_en_i[i]). Disabled streams never receive req_start_o.
- go: asserting req_start_o = stream_en_i, plus eng_start_o=1 for one cycle, combinationally in the same cycle.
- stream_addr_o[i] = base_addr_i[i] + uloop_offs_i[offs_sel_i[i]], modulo 2^ADDR_W, combinational.
- Reset / clear_i:
  - state goes to IDLE and tile_cnt_o to 0.
  - Outputs: uloop_clear_o=1, eng_clear_o=1, eng_enable_o=1; all other outputs 0.
  - clear_i takes priority over every other event in the same cycle.
- States:
  - IDLE: uloop_clear_o=1, eng_clear_o=1. On start_i, go to START and clear tile_cnt.
  - START: eng_clear_o=0. If rdy, issue go and go to COMPUTE; else go to WAIT.
  - WAIT: eng_enable_o=0, eng_clear_o=0. Once rdy, issue go with eng_enable_o=1 and go to COMPUTE.
  - COMPUTE: eng_enable_o=1, eng_clear_o=0. When eng_cnt_i==len_i and eng_acc_valid_i, go to UPDATEIDX and increment tile_cnt (saturates at 0xFFFF).
  - UPDATEIDX, checked in priority order:
    - uloop_valid_i=0: assert uloop_enable_o and stay.
    - else if uloop_done_i: go to TERMINATE.
    - else if rdy: issue go and go to COMPUTE.
    - else: go to WAIT.
  - TERMINATE: eng_enable_o=0. Once rdy (all streams drained), pulse done_o and evt_o for one cycle and go to IDLE.
- busy_o = 1 in every state except IDLE (registered-state decode).
- start_i outside IDLE is ignored.
- len_i==0: COMPUTE exits on the first eng_acc_valid_i with eng_cnt_i==0.
- stream_en_i all zero: rdy is 1; the job runs on engine handshakes only.
- Latency: from start_i to the first req_start_o is 1 cycle when rdy is already high.

Optional Feature:
- Macro: HWPE_MULTISTREAM_FSM_WATCHDOG_EN.
- When defined:
  - A WDOG_W-bit counter increments every cycle in WAIT, COMPUTE or TERMINATE, and resets on any state change.
  - When it reaches all-ones, abort_o pulses for one cycle, done_o pulses, and the FSM goes to IDLE (tile_cnt is held).
- When undefined: no counter is instantiated, abort_o is tied to 0, and the FSM can stall indefinitely.

Test Plan:
- NUM_SRC=3, NUM_SNK=1, all enabled and ready, len=8, uloop done after 2 tiles -> exactly 2 req_start_o=4'b1111 pulses, tile_cnt_o=2, one done_o pulse, busy_o falls in the same cycle as the IDLE return.
- ready_start_i[2]=0 for 5 cycles after start_i -> FSM stays in WAIT with eng_enable_o=0 for those 5 cycles; go fires the cycle stream 2 becomes ready.
- stream_en_i=4'b1011 with ready_start_i[2] stuck at 0 -> the job completes and req_start_o[2] is never asserted.
- base_addr=0x1000, offs_sel=1, uloop_offs[1]=0x40 -> stream_addr_o=0x1040; base 0xFFFFFFF0 with offset 0x20 -> wraps to 0x10.
- clear_i asserted mid-COMPUTE, simultaneous with eng_acc_valid_i -> next cycle state is IDLE, tile_cnt_o=0, no done_o.
- With the macro defined and WDOG_W=4, ready_start_i held at 0 -> abort_o and done_o pulse after 15 cycles in WAIT; the FSM returns to IDLE.
